// File: rtl/ddr2_init_seq.sv
// DDR2 power-up sequencer: CKE/NOP timing, JEDEC PREA/EMRS/MRS/REF list, then DFI handoff.
// Init-side outputs registered; scheduler path is a zero-latency mux after init_done; no backpressure.
module ddr2_init_seq #(
  parameter int CS_WIDTH   = 1,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int T_INIT     = 40000,
  parameter int T_NOP      = 80,
  parameter int T_RP       = 4,
  parameter int T_MRD      = 2,
  parameter int T_RFC      = 26,
  parameter int T_DLL      = 200,
  parameter logic [ADDR_WIDTH-1:0] MR_VAL   = 'h0A52,
  parameter logic [ADDR_WIDTH-1:0] EMR1_VAL = 'h0004
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sch_cke,
  input  logic [CS_WIDTH-1:0]   sch_cs_n,
  input  logic                  sch_ras_n,
  input  logic                  sch_cas_n,
  input  logic                  sch_we_n,
  input  logic [BA_WIDTH-1:0]   sch_ba,
  input  logic [ADDR_WIDTH-1:0] sch_addr,
  input  logic                  sch_odt,
  output logic                  dfi_cke,
  output logic [CS_WIDTH-1:0]   dfi_cs_n,
  output logic                  dfi_ras_n,
  output logic                  dfi_cas_n,
  output logic                  dfi_we_n,
  output logic [BA_WIDTH-1:0]   dfi_ba,
  output logic [ADDR_WIDTH-1:0] dfi_addr,
  output logic                  dfi_odt,
  output logic                  init_done
);

  function automatic int t_max();
    int m;
    m = T_INIT;
    if (T_NOP > m) m = T_NOP;
    if (T_RP  > m) m = T_RP;
    if (T_MRD > m) m = T_MRD;
    if (T_RFC > m) m = T_RFC;
    if (T_DLL > m) m = T_DLL;
    return m;
  endfunction

  localparam int CNT_W = $clog2(t_max());
  localparam int DLL_W = $clog2(T_DLL);

  localparam logic [ADDR_WIDTH-1:0] A10     = ADDR_WIDTH'(1024);
  localparam logic [ADDR_WIDTH-1:0] DLL_RST = ADDR_WIDTH'(256);
  localparam logic [ADDR_WIDTH-1:0] OCD_DEF = ADDR_WIDTH'(896);

  typedef enum logic [2:0] {CKE_LOW, NOP_WAIT, CMD, GAP, DLL_WAIT, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DLL_W-1:0]      dll_cnt;
  logic [3:0]            step;

  logic                  seq_cke;
  logic [CS_WIDTH-1:0]   seq_cs_n;
  logic                  seq_ras_n;
  logic                  seq_cas_n;
  logic                  seq_we_n;
  logic [BA_WIDTH-1:0]   seq_ba;
  logic [ADDR_WIDTH-1:0] seq_addr;

  logic [2:0]            st_rcw;
  logic [BA_WIDTH-1:0]   st_ba;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [CNT_W-1:0]      st_gap_m2;

  // Step table: {ras_n,cas_n,we_n}, bank, address and gap (minus the CMD and reload cycles).
  always_comb begin
    st_rcw    = 3'b000;
    st_ba     = '0;
    st_addr   = '0;
    st_gap_m2 = CNT_W'(T_MRD - 2);
    case (step)
      4'd0, 4'd5: begin st_rcw = 3'b010; st_addr = A10; st_gap_m2 = CNT_W'(T_RP - 2); end
      4'd1:       st_ba = BA_WIDTH'(2);
      4'd2:       st_ba = BA_WIDTH'(3);
      4'd3:       begin st_ba = BA_WIDTH'(1); st_addr = EMR1_VAL; end
      4'd4:       st_addr = MR_VAL | DLL_RST;
      4'd6, 4'd7: begin st_rcw = 3'b001; st_gap_m2 = CNT_W'(T_RFC - 2); end
      4'd8:       st_addr = MR_VAL;
      4'd9:       begin st_ba = BA_WIDTH'(1); st_addr = EMR1_VAL | OCD_DEF; end
      default:    begin st_ba = BA_WIDTH'(1); st_addr = EMR1_VAL; end
    endcase
  end

  // Outputs are registered from the current state, so each state's effect lands one edge later;
  // counter reloads are biased by one to keep absolute timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CKE_LOW;
      cnt       <= CNT_W'(T_INIT - 1);
      dll_cnt   <= '0;
      step      <= '0;
      seq_cke   <= 1'b0;
      seq_cs_n  <= '1;
      seq_ras_n <= 1'b1;
      seq_cas_n <= 1'b1;
      seq_we_n  <= 1'b1;
      seq_ba    <= '0;
      seq_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      seq_cke   <= 1'b1;
      seq_cs_n  <= '0;
      seq_ras_n <= 1'b1;
      seq_cas_n <= 1'b1;
      seq_we_n  <= 1'b1;
      seq_ba    <= '0;
      seq_addr  <= '0;
      init_done <= 1'b0;
      if (dll_cnt != '0) dll_cnt <= dll_cnt - DLL_W'(1);
      case (state)
        CKE_LOW: begin
          seq_cke  <= 1'b0;
          seq_cs_n <= '1;
          if (cnt == '0) begin
            state <= NOP_WAIT;
            cnt   <= CNT_W'(T_NOP - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        NOP_WAIT: begin
          if (cnt == '0) state <= CMD;
          else           cnt   <= cnt - CNT_W'(1);
        end
        CMD: begin
          {seq_ras_n, seq_cas_n, seq_we_n} <= st_rcw;
          seq_ba   <= st_ba;
          seq_addr <= st_addr;
          state    <= GAP;
          cnt      <= st_gap_m2;
          if (step == 4'd4) dll_cnt <= DLL_W'(T_DLL - 2);
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (step == 4'd10) begin
            state <= (dll_cnt == '0) ? DONE : DLL_WAIT;
          end else begin
            step  <= step + 4'd1;
            state <= CMD;
          end
        end
        DLL_WAIT: begin
          if (dll_cnt == '0) state <= DONE;
        end
        DONE: init_done <= 1'b1;
        default: state <= CKE_LOW;
      endcase
    end
  end

  always_comb begin
    if (init_done) begin
      dfi_cke   = sch_cke;
      dfi_cs_n  = sch_cs_n;
      dfi_ras_n = sch_ras_n;
      dfi_cas_n = sch_cas_n;
      dfi_we_n  = sch_we_n;
      dfi_ba    = sch_ba;
      dfi_addr  = sch_addr;
      dfi_odt   = sch_odt;
    end else begin
      dfi_cke   = seq_cke;
      dfi_cs_n  = seq_cs_n;
      dfi_ras_n = seq_ras_n;
      dfi_cas_n = seq_cas_n;
      dfi_we_n  = seq_we_n;
      dfi_ba    = seq_ba;
      dfi_addr  = seq_addr;
      dfi_odt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Directed bench: two sequencers (DLL-limited and gap-limited) checked cycle by cycle against a hand timeline.
module tb_ddr2_init_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sch_cke, sch_cs_n, sch_ras_n, sch_cas_n, sch_we_n, sch_odt;
  logic [2:0]  sch_ba;
  logic [13:0] sch_addr;

  logic        a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_odt, a_done;
  logic [2:0]  a_ba;
  logic [13:0] a_addr;
  logic        b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_odt, b_done;
  logic [2:0]  b_ba;
  logic [13:0] b_addr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ddr2_init_seq #(.T_INIT(20), .T_NOP(8), .T_RP(3), .T_MRD(2), .T_RFC(10), .T_DLL(50)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .sch_cke(sch_cke), .sch_cs_n(sch_cs_n), .sch_ras_n(sch_ras_n), .sch_cas_n(sch_cas_n),
    .sch_we_n(sch_we_n), .sch_ba(sch_ba), .sch_addr(sch_addr), .sch_odt(sch_odt),
    .dfi_cke(a_cke), .dfi_cs_n(a_cs_n), .dfi_ras_n(a_ras_n), .dfi_cas_n(a_cas_n),
    .dfi_we_n(a_we_n), .dfi_ba(a_ba), .dfi_addr(a_addr), .dfi_odt(a_odt), .init_done(a_done)
  );

  ddr2_init_seq #(.T_INIT(20), .T_NOP(8), .T_RP(3), .T_MRD(2), .T_RFC(10), .T_DLL(10)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .sch_cke(sch_cke), .sch_cs_n(sch_cs_n), .sch_ras_n(sch_ras_n), .sch_cas_n(sch_cas_n),
    .sch_we_n(sch_we_n), .sch_ba(sch_ba), .sch_addr(sch_addr), .sch_odt(sch_odt),
    .dfi_cke(b_cke), .dfi_cs_n(b_cs_n), .dfi_ras_n(b_ras_n), .dfi_cas_n(b_cas_n),
    .dfi_we_n(b_we_n), .dfi_ba(b_ba), .dfi_addr(b_addr), .dfi_odt(b_odt), .init_done(b_done)
  );

  logic [23:0] a_vec, b_vec, sch_vec, rst_vec;
  assign a_vec   = {a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_ba, a_addr, a_odt, a_done};
  assign b_vec   = {b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_ba, b_addr, b_odt, b_done};
  assign sch_vec = {sch_cke, sch_cs_n, sch_ras_n, sch_cas_n, sch_we_n, sch_ba, sch_addr, sch_odt, 1'b1};
  assign rst_vec = {1'b0, 1'b1, 3'b111, 3'b000, 14'h0000, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Hand timeline for T_INIT=20, T_NOP=8, T_RP=3, T_MRD=2, T_RFC=10; scheduler owns DFI from done_c on.
  function automatic logic [23:0] exp_vec(input int c, input int done_c, input logic [23:0] sv);
    logic [2:0]  rcw;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        cke;
    if (c >= done_c) return sv;
    rcw  = 3'b111;
    ba   = 3'd0;
    addr = 14'h0000;
    cke  = (c >= 20);
    case (c)
      28, 39: begin rcw = 3'b010; addr = 14'h0400; end
      31:     begin rcw = 3'b000; ba = 3'd2; end
      33:     begin rcw = 3'b000; ba = 3'd3; end
      35, 66: begin rcw = 3'b000; ba = 3'd1; addr = 14'h0004; end
      37:     begin rcw = 3'b000; addr = 14'h0B52; end
      42, 52: rcw = 3'b001;
      62:     begin rcw = 3'b000; addr = 14'h0A52; end
      64:     begin rcw = 3'b000; ba = 3'd1; addr = 14'h0384; end
      default: ;
    endcase
    return {cke, ~cke, rcw, ba, addr, 1'b0, 1'b0};
  endfunction

  task automatic run_seq(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check($sformatf("dll_lim cyc%0d", c), {8'h0, a_vec}, {8'h0, exp_vec(c, 87, sch_vec)});
      check($sformatf("gap_lim cyc%0d", c), {8'h0, b_vec}, {8'h0, exp_vec(c, 68, sch_vec)});
    end
  endtask

  task automatic sch_default();
    sch_cke   = 1'b1;
    sch_cs_n  = 1'b0;
    sch_ras_n = 1'b0;
    sch_cas_n = 1'b1;
    sch_we_n  = 1'b1;
    sch_ba    = 3'd5;
    sch_addr  = 14'h0123;
    sch_odt   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sch_default();
    repeat (3) @(negedge clk);
    check("reset_a", {8'h0, a_vec}, {8'h0, rst_vec});
    check("reset_b", {8'h0, b_vec}, {8'h0, rst_vec});

    // Full sequence from reset release; scheduler stimulus must be ignored until done.
    rst_n = 1'b1;
    run_seq(96);

    // Handoff is combinational: new scheduler values appear without a clock edge.
    sch_cs_n  = 1'b1;
    sch_ras_n = 1'b1;
    sch_cas_n = 1'b0;
    sch_we_n  = 1'b0;
    sch_ba    = 3'd2;
    sch_addr  = 14'h3FFF;
    sch_odt   = 1'b0;
    #1;
    check("handoff_a", {8'h0, a_vec}, {8'h0, 1'b1, 1'b1, 3'b100, 3'd2, 14'h3FFF, 1'b0, 1'b1});
    check("handoff_b", {8'h0, b_vec}, {8'h0, 1'b1, 1'b1, 3'b100, 3'd2, 14'h3FFF, 1'b0, 1'b1});

    // Reset while in DONE returns ownership to the sequencer.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_done_a", {8'h0, a_vec}, {8'h0, rst_vec});
    check("rst_done_b", {8'h0, b_vec}, {8'h0, rst_vec});
    sch_default();

    // Reset during the gap after step 6 (cycle 45), then a full identical rerun.
    rst_n = 1'b1;
    run_seq(46);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_a", {8'h0, a_vec}, {8'h0, rst_vec});
    check("rst_mid_b", {8'h0, b_vec}, {8'h0, rst_vec});
    rst_n = 1'b1;
    run_seq(96);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
